branch_predict_unit: RTL and testbench



---
 rtl/branch_predict_unit.sv | 104 ++++++++++
 tb/tb_branch_predict_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction for the RV32I pipeline: per-PC 2-bit counter
// prediction for IF, funct3 compare and mispredict/redirect for EX, plus statistics.
module branch_predict_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_b_type,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_opr_a,
  input  logic [XLEN-1:0]  ex_opr_b,
  input  logic             ex_pred_taken,
  output logic             branch_taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
  logic [CNT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;
  logic             illegal_q, illegal_d;

  logic             f3_legal;
  logic             br_v;
  logic             cmp;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             unused_if_bits;

  // Only the word-index bits select a counter; the rest alias by design.
  assign if_idx         = if_pc[IDX_W+1:2];
  assign ex_idx         = ex_pc[IDX_W+1:2];
  assign unused_if_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  assign if_pred_taken    = bht_q[if_idx][1];
  assign illegal_branch   = illegal_q;
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

  always_comb begin
    cmp = 1'b0;
    case (ex_funct3)
      3'b000:  cmp = (ex_opr_a == ex_opr_b);
      3'b001:  cmp = (ex_opr_a != ex_opr_b);
      3'b100:  cmp = ($signed(ex_opr_a) <  $signed(ex_opr_b));
      3'b101:  cmp = ($signed(ex_opr_a) >= $signed(ex_opr_b));
      3'b110:  cmp = (ex_opr_a <  ex_opr_b);
      3'b111:  cmp = (ex_opr_a >= ex_opr_b);
      default: cmp = 1'b0;
    endcase
    f3_legal     = (ex_funct3[2:1] != 2'b01);
    br_v         = ex_valid & ex_is_b_type & f3_legal;
    branch_taken = br_v & cmp;
    mispredict   = br_v & (branch_taken != ex_pred_taken);
    redirect_pc  = branch_taken ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));
  end

  always_comb begin
    bht_d              = bht_q;
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    illegal_d          = ex_valid & ex_is_b_type & ~f3_legal;
    if (br_v) begin
      if (branch_taken) begin
        if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
      // Statistics saturate instead of wrapping.
      if (stat_branches_q != '1) stat_branches_d = stat_branches_q + CNT_W'(1);
      if (mispredict && (stat_mispredicts_q != '1))
        stat_mispredicts_d = stat_mispredicts_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
      illegal_q          <= 1'b0;
    end else begin
      bht_q              <= bht_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
      illegal_q          <= illegal_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed vectors push expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int BHT   = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic             ex_valid;
  logic             ex_is_b_type;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_opr_a;
  logic [XLEN-1:0]  ex_opr_b;
  logic             ex_pred_taken;
  logic             branch_taken;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic             illegal_branch;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;

  branch_predict_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(BHT), .CTR_INIT(2'b01), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_b_type(ex_is_b_type), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_opr_a(ex_opr_a), .ex_opr_b(ex_opr_b),
    .ex_pred_taken(ex_pred_taken), .branch_taken(branch_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .illegal_branch(illegal_branch), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    bit         bt;
    bit         mp;
    logic [31:0] rp;
    bit         pred;
    bit         ill;
    logic [3:0] sb;
    logic [3:0] sm;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt   = 0;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every cycle the DUT outputs settle, compare against queued expectations.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc_cnt) begin
        total_cnt++;
        $display("[TB] FAIL %s_stale: got cycle %0d, expected cycle %0d", e.name, cyc_cnt, e.cyc);
      end else begin
        checkOutput({e.name, "_taken"},   32'(branch_taken),     32'(e.bt));
        checkOutput({e.name, "_mispred"}, 32'(mispredict),       32'(e.mp));
        checkOutput({e.name, "_redir"},   redirect_pc,           e.rp);
        checkOutput({e.name, "_pred"},    32'(if_pred_taken),    32'(e.pred));
        checkOutput({e.name, "_illegal"}, 32'(illegal_branch),   32'(e.ill));
        checkOutput({e.name, "_nbr"},     32'(stat_branches),    32'(e.sb));
        checkOutput({e.name, "_nmis"},    32'(stat_mispredicts), 32'(e.sm));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input bit isb, input logic [2:0] f3,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] a, input logic [31:0] b,
                               input bit pred, input logic [31:0] ipc);
    ex_valid      = v;
    ex_is_b_type  = isb;
    ex_funct3     = f3;
    ex_pc         = pc;
    ex_imm        = imm;
    ex_opr_a      = a;
    ex_opr_b      = b;
    ex_pred_taken = pred;
    if_pc         = ipc;
  endtask

  task automatic expect_out(input string name, input bit bt, input bit mp,
                            input logic [31:0] rp, input bit pred, input bit ill,
                            input int sb, input int sm);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.name = name;
    e.bt   = bt;
    e.mp   = mp;
    e.rp   = rp;
    e.pred = pred;
    e.ill  = ill;
    e.sb   = 4'(sb);
    e.sm   = 4'(sm);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] ipc);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, ipc);
  endtask

  initial begin
    rst = 1'b1;
    idle(32'h100);
    repeat (2) next_cycle();
    rst = 1'b0;

    idle(32'h100);
    expect_out("reset", 0, 0, 32'h4, 0, 0, 0, 0);
    next_cycle();
    applyStimulus(1, 1, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 0, 32'h100);
    expect_out("blt", 1, 1, 32'h120, 0, 0, 0, 0);
    next_cycle();
    applyStimulus(1, 1, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 0, 32'h100);
    expect_out("bltu", 0, 0, 32'h104, 1, 0, 1, 1);
    next_cycle();
    applyStimulus(1, 1, 3'b000, 32'h40, 32'h8, 32'h5, 32'h5, 0, 32'h40);
    expect_out("beq1_nobypass", 1, 1, 32'h48, 0, 0, 2, 1);
    next_cycle();
    applyStimulus(1, 1, 3'b000, 32'h40, 32'h8, 32'h5, 32'h5, 1, 32'h40 + 32'(4 * BHT));
    expect_out("beq2_alias", 1, 0, 32'h48, 1, 0, 3, 2);
    next_cycle();
    applyStimulus(1, 1, 3'b000, 32'h40, 32'h8, 32'h5, 32'h5, 1, 32'h40);
    expect_out("beq3", 1, 0, 32'h48, 1, 0, 4, 2);
    next_cycle();
    applyStimulus(1, 1, 3'b001, 32'h40, 32'h8, 32'h5, 32'h5, 1, 32'h40);
    expect_out("bne_nt", 0, 1, 32'h44, 1, 0, 5, 2);
    next_cycle();
    idle(32'h40);
    expect_out("after_nt", 0, 0, 32'h4, 1, 0, 6, 3);
    next_cycle();
    applyStimulus(1, 1, 3'b101, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'h1, 1, 32'h100);
    expect_out("bge", 0, 1, 32'h208, 0, 0, 6, 3);
    next_cycle();
    applyStimulus(1, 1, 3'b111, 32'h204, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h1, 0, 32'h204);
    expect_out("bgeu", 1, 1, 32'h1F4, 0, 0, 7, 4);
    next_cycle();
    applyStimulus(1, 1, 3'b010, 32'h40, 32'h8, 32'h0, 32'h0, 1, 32'h40);
    expect_out("illegal_in", 0, 0, 32'h44, 1, 0, 8, 5);
    next_cycle();
    idle(32'h40);
    expect_out("illegal_pulse", 0, 0, 32'h4, 1, 1, 8, 5);
    next_cycle();
    applyStimulus(0, 1, 3'b010, 32'h40, 32'h8, 32'h0, 32'h0, 1, 32'h40);
    expect_out("illegal_novalid", 0, 0, 32'h44, 1, 0, 8, 5);
    next_cycle();
    applyStimulus(0, 1, 3'b000, 32'h40, 32'h8, 32'h5, 32'h5, 0, 32'h40);
    expect_out("beq_novalid", 0, 0, 32'h44, 1, 0, 8, 5);
    next_cycle();
    idle(32'h40);
    expect_out("no_effect", 0, 0, 32'h4, 1, 0, 8, 5);

    for (int i = 0; i < 20; i++) begin
      next_cycle();
      applyStimulus(1, 1, 3'b000, 32'h300, 32'h40, 32'h1, 32'h2, 1, 32'h300);
      expect_out("sat_loop", 0, 1, 32'h304, 0, 0,
                 (8 + i > 15) ? 15 : 8 + i, (5 + i > 15) ? 15 : 5 + i);
    end
    next_cycle();
    applyStimulus(1, 1, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'h7, 32'h7, 1, 32'h40);
    expect_out("wrap", 1, 0, 32'h10, 1, 0, 15, 15);
    next_cycle();
    rst = 1'b1;
    applyStimulus(1, 1, 3'b000, 32'h40, 32'h8, 32'h5, 32'h5, 0, 32'h40);
    next_cycle();
    rst = 1'b0;
    idle(32'h40);
    expect_out("mid_reset", 0, 0, 32'h4, 0, 0, 0, 0);
    next_cycle();
    idle(32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) next_cycle();
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
